// File: rtl/dcpu2_core.sv
// rtl/dcpu2_core.sv - dual-stack CPU core with shared bus, vectored IRQ, carry, HALT and stack fault
//
// Ports:
//   i_clk     clock, all state on rising edge
//   i_reset   asynchronous active-high reset
//   o_addr    bus address (0 when o_cs=0)
//   o_dat     bus write data (0 when o_cs=0)
//   i_dat     bus read data
//   i_ack     bus cycle complete, may arrive in the same cycle as o_cs
//   o_we      write strobe, valid with o_cs
//   o_cs      bus request
//   i_irq     level-sensitive interrupt request
//   o_halted  core is in HALT
//   o_fault   sticky stack pointer wrap flag

module dcpu2_core #(
  parameter int W = 16,
  parameter int DSS = 5,
  parameter int RSS = 5,
  parameter logic [W-1:0] RESET_PC = '0,
  parameter logic [W-1:0] IRQ_VEC = W'(2)
) (
  input  logic         i_clk,
  input  logic         i_reset,
  output logic [W-1:0] o_addr,
  output logic [W-1:0] o_dat,
  input  logic [W-1:0] i_dat,
  input  logic         i_ack,
  output logic         o_we,
  output logic         o_cs,
  input  logic         i_irq,
  output logic         o_halted,
  output logic         o_fault
);

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_IRQ, S_HALT} state_t;

  state_t state_q, state_d;

  logic [W-1:0]   pc_q, op_q;
  logic [DSS-1:0] dsp_q;
  logic [RSS-1:0] rsp_q;
  logic           ie_q, carry_q, fault_q;

  logic [W-1:0] dstack [0:(1<<DSS)-1];
  logic [W-1:0] rstack [0:(1<<RSS)-1];

  // instruction fields, packed from the MSB down
  logic       is_lit, is_halt;
  logic [2:0] f_dst;
  logic [5:0] f_alu;
  logic [1:0] f_dsp, f_rsp, f_ctl;
  logic [2:0] e_dst;
  logic [1:0] e_dsp, e_rsp, e_ctl;

  assign is_lit  = ~op_q[W-1];
  assign is_halt = &op_q;
  assign f_dst   = op_q[W-2 -: 3];
  assign f_alu   = op_q[W-5 -: 6];
  assign f_dsp   = op_q[W-11 -: 2];
  assign f_rsp   = op_q[W-13 -: 2];
  assign f_ctl   = op_q[W-15 -: 2];

  // a literal behaves as "push to T" with no other side effects
  assign e_dst = is_lit ? 3'd0  : f_dst;
  assign e_dsp = is_lit ? 2'b01 : f_dsp;
  assign e_rsp = is_lit ? 2'b00 : f_rsp;
  assign e_ctl = is_lit ? 2'b00 : f_ctl;

  logic [W-1:0]   t_val, n_val, r_val, pc_inc, alu_res, src;
  logic [DSS-1:0] pick_idx;
  logic [W:0]     sum;

  assign t_val    = dstack[dsp_q];
  assign n_val    = dstack[dsp_q - DSS'(1)];
  assign r_val    = rstack[rsp_q];
  assign pc_inc   = pc_q + W'(1);
  assign pick_idx = dsp_q - t_val[DSS-1:0];

  always_comb begin
    sum     = '0;
    alu_res = '0;
    case (f_alu[4:0])
      5'h00: alu_res = t_val;
      5'h01: alu_res = n_val;
      5'h02: alu_res = r_val;
      5'h03: begin sum = {1'b0, n_val} + {1'b0, t_val}; alu_res = sum[W-1:0]; end
      5'h04: begin sum = {1'b0, n_val} - {1'b0, t_val}; alu_res = sum[W-1:0]; end
      5'h05: alu_res = n_val & t_val;
      5'h06: alu_res = n_val | t_val;
      5'h07: alu_res = n_val ^ t_val;
      5'h08: alu_res = ~t_val;
      5'h0A: alu_res = t_val >> 1;
      5'h0B: begin sum = {t_val, 1'b0}; alu_res = sum[W-1:0]; end
      5'h0C, 5'h0D: alu_res = i_dat;   // only meaningful in MEM at i_ack
      5'h0E: alu_res = (t_val != '0) ? pc_inc : r_val;
      5'h0F: alu_res = (t_val != '0) ? pc_inc : t_val;
      5'h10: alu_res = t_val >> 8;
      5'h11: alu_res = t_val << 8;
      5'h12: alu_res = {{(W-1){1'b0}}, carry_q};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    if (is_lit)        src = {1'b0, op_q[W-2:0]};
    else if (f_alu[5]) src = dstack[pick_idx];
    else               src = alu_res;
  end

  logic alu_carry, mem_wr, mem_rd, go_mem;
  logic [W-1:0] mem_addr;

  assign alu_carry = !is_lit && !f_alu[5] &&
                     (f_alu[4:0] == 5'h03 || f_alu[4:0] == 5'h04 || f_alu[4:0] == 5'h0B);
  assign mem_wr    = !is_lit && (f_dst == 3'd4 || f_dst == 3'd5);
  assign mem_rd    = !is_lit && !f_alu[5] && (f_alu[4:0] == 5'h0C || f_alu[4:0] == 5'h0D);
  // write+read in one word is reserved: no bus access, executes as a NOP
  assign go_mem    = mem_wr ^ mem_rd;
  assign mem_addr  = (mem_wr ? (f_dst == 3'd4) : (f_alu[4:0] == 5'h0C)) ? t_val : r_val;

  logic [DSS-1:0] dsp_n;
  logic [RSS-1:0] rsp_n;
  logic           dsp_wrap, rsp_wrap, ie_n;

  always_comb begin
    dsp_n    = dsp_q;
    dsp_wrap = 1'b0;
    case (e_dsp)
      2'b01: begin dsp_n = dsp_q + DSS'(1); dsp_wrap = &dsp_q; end
      2'b10: begin dsp_n = dsp_q - DSS'(1); dsp_wrap = (dsp_q == '0); end
      default: ;
    endcase
    rsp_n    = rsp_q;
    rsp_wrap = 1'b0;
    case (e_rsp)
      2'b01, 2'b11: begin rsp_n = rsp_q + RSS'(1); rsp_wrap = &rsp_q; end
      2'b10:        begin rsp_n = rsp_q - RSS'(1); rsp_wrap = (rsp_q == '0); end
      default: ;
    endcase
    ie_n = ie_q;
    if (e_ctl == 2'b01)      ie_n = 1'b1;
    else if (e_ctl == 2'b10) ie_n = 1'b0;
  end

  logic           commit, ds_we, rs_we;
  logic [RSS-1:0] rs_waddr;
  logic [W-1:0]   rs_wdat;

  assign commit   = (state_q == S_EXEC && !is_halt && !go_mem) || (state_q == S_MEM && i_ack);
  assign ds_we    = commit && (e_dst == 3'd0 || e_dst == 3'd1);
  assign rs_we    = (commit && (e_rsp == 2'b11 || e_dst == 3'd2)) || state_q == S_IRQ;
  assign rs_waddr = (state_q == S_IRQ) ? rsp_q + RSS'(1) : rsp_n;
  assign rs_wdat  = (state_q == S_IRQ) ? pc_q : ((e_rsp == 2'b11) ? pc_inc : src);

  // FSM: state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (i_ack) state_d = S_EXEC;
      S_EXEC: begin
        if (is_halt)           state_d = S_HALT;
        else if (go_mem)       state_d = S_MEM;
        else if (i_irq && ie_n) state_d = S_IRQ;
        else                   state_d = S_FETCH;
      end
      S_MEM:   if (i_ack) state_d = (i_irq && ie_n) ? S_IRQ : S_FETCH;
      S_IRQ:   state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // FSM: outputs; gated by i_reset so an asserted reset drops the bus at once
  always_comb begin
    o_cs     = 1'b0;
    o_we     = 1'b0;
    o_addr   = '0;
    o_dat    = '0;
    o_halted = 1'b0;
    if (!i_reset) begin
      case (state_q)
        S_FETCH: begin o_cs = 1'b1; o_addr = pc_q; end
        S_MEM: begin
          o_cs   = 1'b1;
          o_addr = mem_addr;
          o_we   = mem_wr;
          o_dat  = mem_wr ? src : '0;
        end
        S_HALT:  o_halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign o_fault = fault_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc_q    <= RESET_PC;
      op_q    <= '0;
      dsp_q   <= '0;
      rsp_q   <= '0;
      ie_q    <= 1'b0;
      carry_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (state_q == S_FETCH && i_ack) op_q <= i_dat;
      if (commit) begin
        pc_q  <= (e_dst == 3'd3) ? src : pc_inc;
        dsp_q <= dsp_n;
        rsp_q <= rsp_n;
        ie_q  <= ie_n;
        if (alu_carry)           carry_q <= sum[W];
        if (dsp_wrap || rsp_wrap) fault_q <= 1'b1;
      end
      if (state_q == S_IRQ) begin
        rsp_q <= rsp_q + RSS'(1);
        pc_q  <= IRQ_VEC;
        ie_q  <= 1'b0;
      end
    end
  end

  // stack RAMs are not reset
  always_ff @(posedge i_clk) begin
    if (!i_reset && ds_we) dstack[dsp_n] <= src;
    if (!i_reset && rs_we) rstack[rs_waddr] <= rs_wdat;
  end

endmodule

// File: tb/tb_dcpu2_core.sv
// tb/tb_dcpu2_core.sv - directed self-checking bench for dcpu2_core

module tb_dcpu2_core;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [15:0] o_addr, o_dat, i_dat;
  logic        i_ack, o_we, o_cs, i_irq, o_halted, o_fault;

  logic [15:0] mem [0:1023];
  int          ack_dly = 0;
  int          wcnt = 0;
  int          wr_cnt = 0;
  int          total = 0;
  int          bad = 0;
  int          wr_base;

  always #5 clk = ~clk;

  dcpu2_core dut (
    .i_clk(clk), .i_reset(i_reset), .o_addr(o_addr), .o_dat(o_dat), .i_dat(i_dat),
    .i_ack(i_ack), .o_we(o_we), .o_cs(o_cs), .i_irq(i_irq), .o_halted(o_halted),
    .o_fault(o_fault)
  );

  // bus slave: ack after ack_dly wait cycles
  assign i_ack = o_cs && (wcnt >= ack_dly);
  assign i_dat = mem[o_addr[9:0]];

  always @(posedge clk) begin
    if (!o_cs || i_ack) wcnt <= 0;
    else                wcnt <= wcnt + 1;
  end

  always @(posedge clk) begin
    if (o_cs && o_we && i_ack) begin
      mem[o_addr[9:0]] = o_dat;
      wr_cnt = wr_cnt + 1;
    end
  end

  function automatic logic [15:0] enc(input int dst, input int alu, input int dsp,
                                      input int rsp, input int ctl);
    return {1'b1, dst[2:0], alu[5:0], dsp[1:0], rsp[1:0], ctl[1:0]};
  endfunction

  function automatic logic [15:0] lit(input int v);
    return {1'b0, v[14:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_reset(input int dly);
    i_reset = 1'b1;
    i_irq   = 1'b0;
    ack_dly = dly;
    @(negedge clk);
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
  endtask

  task automatic release_reset();
    @(negedge clk);
    i_reset = 1'b0;
    #1;
  endtask

  initial begin
    // ---- reset state
    hold_reset(0);
    chk("rst_cs", o_cs, 0);
    chk("rst_we", o_we, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_halted", o_halted, 0);
    chk("rst_fault", o_fault, 0);
    chk("rst_pc", dut.pc_q, 0);

    // ---- 1: literals + ADD, then FFFF+1 carry, then read carry
    mem[0] = lit(5);
    mem[1] = lit(7);
    mem[2] = enc(0, 'h03, 2, 0, 0);
    mem[3] = lit(0);
    mem[4] = enc(0, 'h08, 0, 0, 0);
    mem[5] = lit(1);
    mem[6] = enc(0, 'h03, 2, 0, 0);
    mem[7] = enc(0, 'h12, 1, 0, 0);
    release_reset();
    chk("fetch0_cs", o_cs, 1);
    chk("fetch0_addr", o_addr, 0);
    clk_n(6);
    chk("add_t", dut.t_val, 12);
    chk("add_dsp", dut.dsp_q, 1);
    chk("add_carry", dut.carry_q, 0);
    chk("add_pc", dut.pc_q, 3);
    clk_n(8);
    chk("addc_t", dut.t_val, 0);
    chk("addc_carry", dut.carry_q, 1);
    chk("addc_dsp", dut.dsp_q, 2);
    clk_n(2);
    chk("rdcarry_t", dut.t_val, 1);
    chk("rdcarry_dsp", dut.dsp_q, 3);

    // ---- 2: store with 3 wait states, then read back
    hold_reset(3);
    mem[0] = lit('h1234);
    mem[1] = lit('h0040);
    mem[2] = enc(4, 'h01, 0, 0, 0);
    mem[3] = enc(0, 'h0C, 0, 0, 0);
    wr_base = wr_cnt;
    release_reset();
    clk_n(15);
    chk("st_cs", o_cs, 1);
    chk("st_we", o_we, 1);
    chk("st_addr", o_addr, 'h0040);
    chk("st_dat", o_dat, 'h1234);
    clk_n(2);
    chk("st_hold_we", o_we, 1);
    chk("st_hold_addr", o_addr, 'h0040);
    chk("st_hold_dat", o_dat, 'h1234);
    chk("st_nowrite_yet", wr_cnt - wr_base, 0);
    clk_n(2);
    chk("st_one_write", wr_cnt - wr_base, 1);
    chk("st_mem", mem[64], 'h1234);
    clk_n(9);
    chk("ld_t", dut.t_val, 'h1234);
    chk("ld_pc", dut.pc_q, 4);
    chk("ld_writes", wr_cnt - wr_base, 1);

    // ---- 3: call / return
    hold_reset(0);
    mem[0]     = lit('h0100);
    mem[1]     = enc(3, 'h00, 2, 3, 0);
    mem[2]     = lit(3);
    mem['h100] = lit(9);
    mem['h101] = enc(3, 'h02, 0, 2, 0);
    release_reset();
    clk_n(4);
    chk("call_pc", dut.pc_q, 'h0100);
    chk("call_rsp", dut.rsp_q, 1);
    chk("call_r", dut.r_val, 2);
    clk_n(4);
    chk("ret_pc", dut.pc_q, 2);
    chk("ret_rsp", dut.rsp_q, 0);
    clk_n(2);
    chk("ret_resume_t", dut.t_val, 3);
    chk("ret_fault", o_fault, 0);

    // ---- 4: interrupt gated by ie, entry, return with EI
    hold_reset(0);
    mem[0]    = lit('h10);
    mem[1]    = enc(3, 'h00, 2, 0, 0);
    mem[2]    = enc(3, 'h02, 0, 2, 1);
    mem['h10] = enc(6, 'h00, 0, 0, 1);
    mem['h11] = lit('h55);
    i_irq = 1'b1;
    release_reset();
    clk_n(4);
    chk("irq_masked_pc", dut.pc_q, 'h10);
    chk("irq_masked_rsp", dut.rsp_q, 0);
    clk_n(2);
    chk("ei_pc", dut.pc_q, 'h11);
    chk("ei_ie", dut.ie_q, 1);
    chk("irq_state_cs", o_cs, 0);
    clk_n(1);
    chk("irq_pc", dut.pc_q, 2);
    chk("irq_r", dut.r_val, 'h11);
    chk("irq_ie", dut.ie_q, 0);
    chk("irq_rsp", dut.rsp_q, 1);
    chk("irq_fetch_addr", o_addr, 2);
    i_irq = 1'b0;
    clk_n(2);
    chk("reti_pc", dut.pc_q, 'h11);
    chk("reti_ie", dut.ie_q, 1);
    chk("reti_rsp", dut.rsp_q, 0);
    clk_n(2);
    chk("resume_t", dut.t_val, 'h55);
    chk("resume_pc", dut.pc_q, 'h12);

    // ---- 5: data stack overflow, return stack underflow
    hold_reset(0);
    for (int k = 0; k < 33; k++) mem[k] = lit(k + 1);
    release_reset();
    clk_n(62);
    chk("ovf31_fault", o_fault, 0);
    chk("ovf31_dsp", dut.dsp_q, 31);
    clk_n(2);
    chk("ovf32_fault", o_fault, 1);
    chk("ovf32_dsp", dut.dsp_q, 0);
    clk_n(2);
    chk("ovf33_fault", o_fault, 1);
    chk("ovf33_dsp", dut.dsp_q, 1);
    hold_reset(0);
    chk("fault_cleared", o_fault, 0);
    mem[0] = enc(6, 'h00, 0, 2, 0);
    release_reset();
    clk_n(2);
    chk("unf_fault", o_fault, 1);
    chk("unf_rsp", dut.rsp_q, 31);

    // ---- 6: reset during MEM wait, then HALT
    hold_reset(3);
    mem[0] = lit('h40);
    mem[1] = enc(0, 'h0C, 0, 0, 0);
    release_reset();
    clk_n(10);
    chk("mw_cs", o_cs, 1);
    chk("mw_addr", o_addr, 'h40);
    #2;
    i_reset = 1'b1;
    #1;
    chk("mw_rst_cs", o_cs, 0);
    chk("mw_rst_addr", o_addr, 0);
    chk("mw_rst_pc", dut.pc_q, 0);
    hold_reset(0);
    mem[0] = 16'hFFFF;
    i_irq  = 1'b1;
    release_reset();
    clk_n(2);
    chk("halt_flag", o_halted, 1);
    chk("halt_cs", o_cs, 0);
    clk_n(5);
    chk("halt_stay", o_halted, 1);
    chk("halt_cs2", o_cs, 0);
    chk("halt_pc", dut.pc_q, 0);
    i_reset = 1'b1;
    #1;
    chk("halt_exit", o_halted, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
